// File: rtl/spi_frame_master.sv
// spi_frame_master: SPI mode-0 master that serialises one keyboard note frame
// (sync word, three 32-bit note periods, control word) MSB-first toward the
// synthesiser's receive-only slave. sck is derived from clk by CLK_DIV.
// Optional feature macro: SPI_FRAME_SYNC_EVERY_FRAME_EN
//   defined   -> every frame is 160 bits and starts with SYNC_WORD
//   undefined -> only the first frame after reset carries SYNC_WORD; later
//                frames are 128 bits starting at prd1
module spi_frame_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [31:0] SYNC_WORD = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] prd1_in,
    input  logic [31:0] prd2_in,
    input  logic [31:0] prd3_in,
    input  logic [1:0]  waveform_in,
    input  logic [1:0]  notes_in,
    output logic        sck,
    output logic        sdo,
    output logic        busy,
    output logic        done
);

    localparam int unsigned FRAME_W = 160;
    localparam int unsigned BIT_W   = 8;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV) + 1;

    localparam logic [BIT_W-1:0] LAST_SYNC   = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] LAST_NOSYNC = BIT_W'(127);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        FINISH   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shadow_q, shadow_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               sck_q, sck_d;
    logic               sdo_q, sdo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0]        ctrl_c;
    logic               use_sync_c;
    logic [BIT_W-1:0]   last_bit_c;

    assign ctrl_c = {28'b0, notes_in, waveform_in};

`ifdef SPI_FRAME_SYNC_EVERY_FRAME_EN
    assign use_sync_c = 1'b1;
    assign last_bit_c = LAST_SYNC;
`else
    logic synced_q, synced_d;

    // Sticky flag: the preamble has gone out once since reset.
    always_comb begin
        synced_d = synced_q | (state_q == FINISH);
    end

    // Synced flag register, cleared by reset so the preamble is re-sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced_q <= 1'b0;
        end else begin
            synced_q <= synced_d;
        end
    end

    assign use_sync_c = ~synced_q;
    assign last_bit_c = synced_q ? LAST_NOSYNC : LAST_SYNC;
`endif

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        bit_d    = bit_q;
        div_d    = div_q;
        sck_d    = sck_q;
        sdo_d    = sdo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (use_sync_c) begin
                        shadow_d = {SYNC_WORD, prd1_in, prd2_in, prd3_in, ctrl_c};
                    end else begin
                        shadow_d = {prd1_in, prd2_in, prd3_in, ctrl_c, 32'h0};
                    end
                    sdo_d   = shadow_d[FRAME_W-1];
                    bit_d   = '0;
                    div_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == last_bit_c) begin
                        sdo_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        // Next bit is presented on the falling sck edge.
                        shadow_d = {shadow_q[FRAME_W-2:0], 1'b0};
                        sdo_d    = shadow_q[FRAME_W-2];
                        bit_d    = bit_q + BIT_W'(1);
                        state_d  = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            sck_q    <= sck_d;
            sdo_q    <= sdo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sck  = sck_q;
    assign sdo  = sdo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a bench-side SPI slave captures sdo on sck
// rising edges; captured frames, busy lengths and done pulses are checked
// against a frame model built from the note-frame format.
module tb_spi_frame_master;

    localparam int unsigned CLK_DIV = 2;
    localparam logic [31:0] SYNC    = 32'h0000_FFFF;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] prd1_in, prd2_in, prd3_in;
    logic [1:0]  waveform_in, notes_in;
    logic        sck, sdo, busy, done;

    int tests = 0;
    int fails = 0;

    logic cap[$];
    int   busy_len[$];
    int   busy_run = 0;
    bit   model_synced = 0;

    spi_frame_master #(.CLK_DIV(CLK_DIV), .SYNC_WORD(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .prd1_in     (prd1_in),
        .prd2_in     (prd2_in),
        .prd3_in     (prd3_in),
        .waveform_in (waveform_in),
        .notes_in    (notes_in),
        .sck         (sck),
        .sdo         (sdo),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench slave: sample sdo on every rising sck edge.
    always @(posedge sck) cap.push_back(sdo);

    // Record the length of each completed busy period.
    always @(negedge clk) begin
        if (!rst_n) busy_run = 0;
        else if (busy === 1'b1) busy_run++;
        else if (busy_run != 0) begin
            busy_len.push_back(busy_run);
            busy_run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit sync_next();
`ifdef SPI_FRAME_SYNC_EVERY_FRAME_EN
        return 1'b1;
`else
        return !model_synced;
`endif
    endfunction

    // Frame model, left-aligned in 160 bits.
    function automatic logic [159:0] model_frame(input bit with_sync, input logic [31:0] p1,
            input logic [31:0] p2, input logic [31:0] p3, input logic [1:0] wf, input logic [1:0] nt);
        logic [31:0] ctrl;
        ctrl = {28'b0, nt, wf};
        if (with_sync) return {SYNC, p1, p2, p3, ctrl};
        return {p1, p2, p3, ctrl, 32'h0};
    endfunction

    function automatic logic [159:0] cap_vec(input int base, input int n);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < n && i < 160; i++) v[159-i] = cap[base+i];
        return v;
    endfunction

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
            input logic [1:0] wf, input logic [1:0] nt, input bit inject);
        bit           use_sync, got;
        int           nbits, base, bbase;
        logic [159:0] expv;
        use_sync = sync_next();
        nbits    = use_sync ? 160 : 128;
        expv     = model_frame(use_sync, p1, p2, p3, wf, nt);
        base     = cap.size();
        bbase    = busy_len.size();
        prd1_in = p1; prd2_in = p2; prd3_in = p3; waveform_in = wf; notes_in = nt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
        check("sdo_first", sdo, expv[159]);
        repeat (CLK_DIV - 1) @(negedge clk);
        check("sck_low_phase", sck, 0);
        @(negedge clk);
        check("sck_first_rise", sck, 1);
        if (inject) begin
            repeat (10) @(negedge clk);
            prd1_in = 32'hDEAD_BEEF;
            repeat (40) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(got);
        check("done_seen", got, 1);
        check("done_idle_state", {sck, sdo, busy}, 3'b000);
        @(negedge clk);
        check("done_single", done, 0);
        check("bit_count", cap.size() - base, nbits);
        check("frame_bits", cap_vec(base, nbits), expv);
        check("busy_len_count", busy_len.size() - bbase, 1);
        if (busy_len.size() > bbase)
            check("busy_len", busy_len[bbase], nbits * 2 * CLK_DIV);
        model_synced = 1'b1;
    endtask

    initial begin
        bit           got, s1, s2;
        int           base, bbase, n1, n2, seen_done;
        logic [31:0]  r1, r2, r3;
        logic [1:0]   rw, rn;

        rst_n = 1'b0; start = 1'b0;
        prd1_in = '0; prd2_in = '0; prd3_in = '0; waveform_in = '0; notes_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {sck, sdo, busy, done}, 4'b0000);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("reset_idle", {sck, sdo, busy, done}, 4'b0000);
        end

        // Basic frame with mid-frame input change and ignored second start.
        run_frame(32'h0001_2345, 32'h0000_ABCD, 32'h0000_0400, 2'b10, 2'b11, 1'b1);
        check("basic_literal", cap_vec(cap.size() - 160, 160),
              160'h0000FFFF_00012345_0000ABCD_00000400_0000000E);

        // Second frame: sync depends on the build option.
        run_frame($urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b0);

        // Back-to-back frames with start held high.
        r1 = $urandom; r2 = $urandom; r3 = $urandom; rw = 2'($urandom); rn = 2'($urandom);
        prd1_in = r1; prd2_in = r2; prd3_in = r3; waveform_in = rw; notes_in = rn;
        base = cap.size(); bbase = busy_len.size();
        s1 = sync_next(); n1 = s1 ? 160 : 128;
        model_synced = 1'b1;
        s2 = sync_next(); n2 = s2 ? 160 : 128;
        start = 1'b1;
        wait_done(got);
        check("b2b_done1", got, 1);
        @(negedge clk);
        check("b2b_idle_gap", {sck, sdo, busy, done}, 4'b0000);
        @(negedge clk);
        check("b2b_restart", busy, 1);
        start = 1'b0;
        wait_done(got);
        check("b2b_done2", got, 1);
        repeat (3) @(negedge clk);
        check("b2b_bits", cap.size() - base, n1 + n2);
        check("b2b_frame1", cap_vec(base, n1), model_frame(s1, r1, r2, r3, rw, rn));
        check("b2b_frame2", cap_vec(base + n1, n2), model_frame(s2, r1, r2, r3, rw, rn));
        check("b2b_busy_count", busy_len.size() - bbase, 2);
        if (busy_len.size() >= bbase + 2) begin
            check("b2b_busy1", busy_len[bbase], n1 * 2 * CLK_DIV);
            check("b2b_busy2", busy_len[bbase+1], n2 * 2 * CLK_DIV);
        end

        // Reset in the middle of a frame.
        base = cap.size();
        prd1_in = $urandom; prd2_in = $urandom; prd3_in = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (cap.size() - base >= 50) got = 1'b1;
        end
        check("midreset_reached50", got, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {sck, sdo, busy, done}, 4'b0000);
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        rst_n = 1'b1;
        model_synced = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("midreset_no_done", seen_done, 0);
        check("midreset_no_sck", cap.size() - base, 50);

        // Frames after reset: sync re-sent, then randomized frames.
        run_frame($urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b0);
        for (int k = 0; k < 3; k++)
            run_frame($urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
